// File: rtl/digit_entry_reg_pkg.sv
// Shared calculator definitions: digit-buffer geometry and keypad codes.
// The key-code constants are also used by the calculator control FSM.
package digit_entry_reg_pkg;

    localparam int NDIG_DEF = 4;
    localparam int DW_DEF   = 4;

    // Largest key code that is a decimal digit; everything above is a function key.
    localparam int DIGIT_MAX = 9;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_MUL = 4'd12;
    localparam logic [3:0] KEY_DIV = 4'd13;
    localparam logic [3:0] KEY_EQ  = 4'd14;
    localparam logic [3:0] KEY_CLR = 4'd15;

endpackage

// File: rtl/digit_entry_reg.sv
// Keypad-side digit buffer for the 4-digit display path.
// Digit 0 (bits [3:0]) is the right-most digit; new keys shift in from the right.
// Strobe priority in one cycle: rst > key_clr > load_valid > key_bksp > key_valid.
module digit_entry_reg
    import digit_entry_reg_pkg::*;
#(
    parameter int NDIG = NDIG_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid,
    input  logic [DW-1:0]       key_code,
    input  logic                key_clr,
    input  logic                key_bksp,
    input  logic                load_valid,
    input  logic [NDIG*DW-1:0]  load_data,
    output logic [NDIG*DW-1:0]  digits,
    output logic [2:0]          count,
    output logic [NDIG-1:0]     blank,
    output logic                full,
    output logic                ovf,
    output logic                bad_key
);

    logic [NDIG*DW-1:0] digits_q, digits_d;
    logic [2:0]         count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               bad_key_q, bad_key_d;
    logic               full_w;
    logic [NDIG-1:0]    blank_w;

    // Entered-digit count implied by a loaded value: one past the highest
    // nonzero nibble, with an all-zero value still showing a single "0".
    function automatic logic [2:0] lead_count(input logic [NDIG*DW-1:0] d);
        logic [2:0] n;
        n = 3'd1;
        for (int i = 0; i < NDIG; i++) begin
            if (d[i*DW +: DW] != '0) n = 3'(i + 1);
        end
        return n;
    endfunction

    assign full_w = (count_q == 3'(NDIG));

    // Next-state selection by strobe priority; dropped strobes never pulse.
    always_comb begin
        digits_d  = digits_q;
        count_d   = count_q;
        ovf_d     = 1'b0;
        bad_key_d = 1'b0;
        if (key_clr) begin
            digits_d = '0;
            count_d  = '0;
        end else if (load_valid) begin
            digits_d = load_data;
            count_d  = lead_count(load_data);
        end else if (key_bksp) begin
            if (count_q != 3'd0) begin
                digits_d = digits_q >> DW;
                count_d  = count_q - 3'd1;
            end
        end else if (key_valid) begin
            if (key_code > DW'(DIGIT_MAX)) begin
                bad_key_d = 1'b1;
            end else if (full_w) begin
                ovf_d = 1'b1;
            end else if (!(count_q == 3'd0 && key_code == '0)) begin
                // A zero keyed into an empty entry is swallowed so no leading zeros build up.
                digits_d = {digits_q[NDIG*DW-DW-1:0], key_code};
                count_d  = count_q + 3'd1;
            end
        end
    end

    // State and pulse registers; reset wins over any strobe in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            bad_key_q <= 1'b0;
        end else begin
            digits_q  <= digits_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            bad_key_q <= bad_key_d;
        end
    end

    // Leading positions are blanked; digit 0 always lights so an empty entry shows "0".
    always_comb begin
        blank_w    = '0;
        blank_w[0] = 1'b0;
        for (int i = 1; i < NDIG; i++) begin
            blank_w[i] = (3'(i) >= count_q);
        end
    end

    assign digits  = digits_q;
    assign count   = count_q;
    assign blank   = blank_w;
    assign full    = full_w;
    assign ovf     = ovf_q;
    assign bad_key = bad_key_q;

endmodule

// File: tb/tb_digit_entry_reg.sv
// Self-checking bench for digit_entry_reg: directed vector table, a reset
// corner sequence, then random strobes against a nibble-array reference model.
module tb_digit_entry_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_clr;
    logic        key_bksp;
    logic        load_valid;
    logic [15:0] load_data;
    logic [15:0] digits;
    logic [2:0]  count;
    logic [3:0]  blank;
    logic        full;
    logic        ovf;
    logic        bad_key;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    digit_entry_reg dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_clr    (key_clr),
        .key_bksp   (key_bksp),
        .load_valid (load_valid),
        .load_data  (load_data),
        .digits     (digits),
        .count      (count),
        .blank      (blank),
        .full       (full),
        .ovf        (ovf),
        .bad_key    (bad_key)
    );

    typedef struct {
        logic        rst;
        logic        clr;
        logic        ld;
        logic [15:0] ldata;
        logic        bk;
        logic        kv;
        logic [3:0]  kc;
        logic [15:0] e_dig;
        int          e_cnt;
        logic        e_ovf;
        logic        e_bad;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic c, logic l, logic [15:0] ld, logic b,
                                logic k, logic [3:0] kc, logic [15:0] ed, int ec,
                                logic eo, logic eb);
        vec_t v;
        v.rst = r; v.clr = c; v.ld = l; v.ldata = ld; v.bk = b; v.kv = k; v.kc = kc;
        v.e_dig = ed; v.e_cnt = ec; v.e_ovf = eo; v.e_bad = eb;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(string tag, logic [15:0] e_dig, int e_cnt, logic e_ovf, logic e_bad);
        logic [3:0] e_blank;
        e_blank = 4'b0000;
        for (int i = 1; i < 4; i++) e_blank[i] = (i >= e_cnt);
        chk({tag, ".digits"}, int'(digits), int'(e_dig));
        chk({tag, ".count"}, int'(count), e_cnt);
        chk({tag, ".blank"}, int'(blank), int'(e_blank));
        chk({tag, ".full"}, int'(full), (e_cnt == 4) ? 1 : 0);
        chk({tag, ".ovf"}, int'(ovf), int'(e_ovf));
        chk({tag, ".bad_key"}, int'(bad_key), int'(e_bad));
    endtask

    task automatic drive(logic r, logic c, logic l, logic [15:0] ld, logic b, logic k, logic [3:0] kc);
        rst = r; key_clr = c; load_valid = l; load_data = ld;
        key_bksp = b; key_valid = k; key_code = kc;
        @(posedge clk);
        #1;
    endtask

    // Reference model: four nibbles plus entered-digit count, updated by the
    // documented rules in priority order.
    int m_dig[4];
    int m_cnt;
    logic m_ovf, m_bad;

    task automatic model_step(logic r, logic c, logic l, logic [15:0] ld, logic b, logic k, logic [3:0] kc);
        m_ovf = 1'b0;
        m_bad = 1'b0;
        if (r || c) begin
            for (int i = 0; i < 4; i++) m_dig[i] = 0;
            m_cnt = 0;
        end else if (l) begin
            m_cnt = 1;
            for (int i = 0; i < 4; i++) begin
                m_dig[i] = int'((ld >> (4 * i)) & 16'hF);
                if (m_dig[i] != 0) m_cnt = i + 1;
            end
        end else if (b) begin
            if (m_cnt > 0) begin
                for (int i = 0; i < 3; i++) m_dig[i] = m_dig[i + 1];
                m_dig[3] = 0;
                m_cnt--;
            end
        end else if (k) begin
            if (kc > 4'd9) m_bad = 1'b1;
            else if (m_cnt == 4) m_ovf = 1'b1;
            else if (!(m_cnt == 0 && kc == 4'd0)) begin
                for (int i = 3; i > 0; i--) m_dig[i] = m_dig[i - 1];
                m_dig[0] = int'(kc);
                m_cnt++;
            end
        end
    endtask

    function automatic logic [15:0] model_digits();
        int v;
        v = 0;
        for (int i = 0; i < 4; i++) v = v + (m_dig[i] << (4 * i));
        return 16'(v);
    endfunction

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_code = 4'd0; key_clr = 1'b0;
        key_bksp = 1'b0; load_valid = 1'b0; load_data = 16'h0;

        //          rst clr ld ldata    bk kv kc     e_dig    cnt ovf bad
        vecs.push_back(mk(1, 0, 0, 16'h0,    0, 0, 4'd0,  16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 1, 4'd1,  16'h0001, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 1, 4'd2,  16'h0012, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 1, 4'd3,  16'h0123, 3, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 1, 4'd4,  16'h1234, 4, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 1, 4'd5,  16'h1234, 4, 1, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 0, 4'd0,  16'h1234, 4, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0,    0, 0, 4'd0,  16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 1, 4'd0,  16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 1, 4'd0,  16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 1, 4'd7,  16'h0007, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0,    0, 0, 4'd0,  16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 1, 4'd1,  16'h0001, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 1, 4'd2,  16'h0012, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 1, 4'd3,  16'h0123, 3, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0,    1, 0, 4'd0,  16'h0012, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0,    1, 0, 4'd0,  16'h0001, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0,    1, 0, 4'd0,  16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0,    1, 0, 4'd0,  16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0405, 0, 0, 4'd0,  16'h0405, 3, 0, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0000, 0, 0, 4'd0,  16'h0000, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 16'h9000, 0, 0, 4'd0,  16'h9000, 4, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0,    0, 1, 4'd9,  16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 1, 4'd1,  16'h0001, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 1, 4'd2,  16'h0012, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0,    1, 1, 4'd6,  16'h0001, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 1, 4'd12, 16'h0001, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 0, 4'd0,  16'h0001, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 16'h1234, 0, 1, 4'd15, 16'h1234, 4, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0,    0, 1, 4'd0,  16'h1234, 4, 1, 0));

        foreach (vecs[n]) begin
            drive(vecs[n].rst, vecs[n].clr, vecs[n].ld, vecs[n].ldata,
                  vecs[n].bk, vecs[n].kv, vecs[n].kc);
            check_all($sformatf("vec%0d", n), vecs[n].e_dig, vecs[n].e_cnt,
                      vecs[n].e_ovf, vecs[n].e_bad);
        end

        // Reset asserted with a key pending while two digits are held: key is lost.
        drive(0, 1, 0, 16'h0, 0, 0, 4'd0);
        drive(0, 0, 0, 16'h0, 0, 1, 4'd4);
        drive(0, 0, 0, 16'h0, 0, 1, 4'd2);
        check_all("pre_rst", 16'h0042, 2, 0, 0);
        drive(1, 0, 0, 16'h0, 0, 1, 4'd3);
        check_all("rst_key", 16'h0000, 0, 0, 0);
        drive(0, 0, 0, 16'h0, 0, 1, 4'd8);
        check_all("post_rst", 16'h0008, 1, 0, 0);

        // Random strobes against the reference model.
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
        m_cnt = 0;
        drive(1, 0, 0, 16'h0, 0, 0, 4'd0);
        model_step(1, 0, 0, 16'h0, 0, 0, 4'd0);
        for (int n = 0; n < 600; n++) begin
            logic r, c, l, b, k;
            logic [3:0] kc;
            logic [15:0] ld;
            r  = ($urandom_range(0, 49) == 0);
            c  = ($urandom_range(0, 14) == 0);
            l  = ($urandom_range(0, 11) == 0);
            b  = ($urandom_range(0, 4) == 0);
            k  = ($urandom_range(0, 1) == 1);
            kc = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
            ld = 16'($urandom) & {{4{1'($urandom_range(0, 1))}}, {4{1'($urandom_range(0, 1))}},
                                  {4{1'($urandom_range(0, 1))}}, {4{1'($urandom_range(0, 1))}}};
            model_step(r, c, l, ld, b, k, kc);
            drive(r, c, l, ld, b, k, kc);
            check_all($sformatf("rnd%0d", n), model_digits(), m_cnt, m_ovf, m_bad);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
